respondedor_memoria: RTL and testbench

RESPONDEDOR_MEMORIA -- requirements
Module: respondedor_memoria

---
 rtl/respondedor_memoria_pkg.sv | 33 +++
 rtl/respondedor_memoria_if.sv | 25 ++
 rtl/respondedor_memoria_alineador_bytes.sv | 48 ++++
 rtl/respondedor_memoria.sv | 129 ++++++++++++
 tb/tb_respondedor_memoria.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/respondedor_memoria_pkg.sv
// Shared types for the memory responder: access sizes, FSM states and the
// alignment rule used by both the lane aligner and the top-level FSM.
package respondedor_memoria_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    MEDIA     = 2'b01,
    PALABRA   = 2'b10,
    RESERVADO = 2'b11
  } tam_t;

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    ESPERA   = 2'b01,
    RESPONDE = 2'b10
  } estado_t;

  localparam int ANCHO_DATO   = 32;
  localparam int ANCHO_CUENTA = 4;

  // Reserved size is always an error; halves need an even address, words a 4-aligned one.
  function automatic logic es_desalineado(input tam_t tam, input logic [1:0] dir_lo);
    logic resultado;
    case (tam)
      BYTE:    resultado = 1'b0;
      MEDIA:   resultado = dir_lo[0];
      PALABRA: resultado = (dir_lo != 2'b00);
      default: resultado = 1'b1;
    endcase
    return resultado;
  endfunction

endpackage

// File: rtl/respondedor_memoria_if.sv
// Request/response bus between the datapath (master) and the memory responder (slave).
interface respondedor_memoria_if;
  import respondedor_memoria_pkg::*;

  logic        sol;
  logic        esc_mem;
  logic [31:0] dir;
  logic [31:0] dat_escritura;
  tam_t        tam;
  logic        sin_signo;
  logic [31:0] dat_lectura;
  logic        listo;
  logic        error_alineacion;

  modport master (
    output sol, esc_mem, dir, dat_escritura, tam, sin_signo,
    input  dat_lectura, listo, error_alineacion
  );

  modport slave (
    input  sol, esc_mem, dir, dat_escritura, tam, sin_signo,
    output dat_lectura, listo, error_alineacion
  );

endinterface

// File: rtl/respondedor_memoria_alineador_bytes.sv
// Combinational lane logic: merges store data into the addressed word and
// extracts/extends load data from it.
module alineador_bytes
  import respondedor_memoria_pkg::*;
(
  input  tam_t        i_tam,
  input  logic [1:0]  i_dir_lo,
  input  logic        i_sin_signo,
  input  logic [31:0] i_dat_escritura,
  input  logic [31:0] i_palabra_ram,
  output logic [31:0] o_palabra_nueva,
  output logic [31:0] o_dat_cargado,
  output logic        o_desalineado
);

  logic [4:0]  w_desp_byte;
  logic [4:0]  w_desp_media;
  logic [7:0]  w_byte;
  logic [15:0] w_media;

  assign w_desp_byte   = {i_dir_lo, 3'b000};
  assign w_desp_media  = {i_dir_lo[1], 4'b0000};
  assign w_byte        = i_palabra_ram[w_desp_byte +: 8];
  assign w_media       = i_palabra_ram[w_desp_media +: 16];
  assign o_desalineado = es_desalineado(i_tam, i_dir_lo);

  // Untouched lanes keep the current RAM contents so a full-word write is a safe merge.
  always_comb begin
    o_palabra_nueva = i_palabra_ram;
    o_dat_cargado   = '0;
    case (i_tam)
      BYTE: begin
        o_palabra_nueva[w_desp_byte +: 8] = i_dat_escritura[7:0];
        o_dat_cargado = {{24{w_byte[7] & ~i_sin_signo}}, w_byte};
      end
      MEDIA: begin
        o_palabra_nueva[w_desp_media +: 16] = i_dat_escritura[15:0];
        o_dat_cargado = {{16{w_media[15] & ~i_sin_signo}}, w_media};
      end
      PALABRA: begin
        o_palabra_nueva = i_dat_escritura;
        o_dat_cargado   = i_palabra_ram;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/respondedor_memoria.sv
// Word-organised RAM that answers byte/half/word loads and stores after a
// programmable number of wait cycles, with a one-cycle response strobe.
module respondedor_memoria
  import respondedor_memoria_pkg::*;
#(
  parameter int PALABRAS = 256,
  parameter int LATENCIA = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  respondedor_memoria_if.slave  bus
);

  localparam int ANCHO_IDX  = $clog2(PALABRAS);
  localparam bit SIN_ESPERA = (LATENCIA == 0);
  localparam logic [ANCHO_CUENTA-1:0] CARGA =
    (LATENCIA > 0) ? ANCHO_CUENTA'(LATENCIA - 1) : '0;

  estado_t                 r_estado;
  logic [ANCHO_CUENTA-1:0] r_cuenta;
  logic [ANCHO_IDX+1:0]    r_dir;
  logic [31:0]             r_dat_escritura;
  logic                    r_esc_mem;
  tam_t                    r_tam;
  logic                    r_sin_signo;
  logic [31:0]             r_dat_lectura;
  logic                    r_listo;
  logic                    r_error;
  logic [31:0]             r_ram [PALABRAS];

  logic                    w_en_reposo;
  logic [ANCHO_IDX+1:0]    w_dir;
  logic [31:0]             w_dat_escritura;
  logic                    w_esc_mem;
  tam_t                    w_tam;
  logic                    w_sin_signo;
  logic [ANCHO_IDX-1:0]    w_indice;
  logic [31:0]             w_palabra_ram;
  logic [31:0]             w_palabra_nueva;
  logic [31:0]             w_dat_cargado;
  logic                    w_desalineado;
  logic                    w_entra_responde;
  logic                    w_escribe;

  // With zero latency the response edge is the capture edge, so operands come straight off the bus.
  assign w_en_reposo     = (r_estado == REPOSO);
  assign w_dir           = w_en_reposo ? bus.dir[ANCHO_IDX+1:0] : r_dir;
  assign w_dat_escritura = w_en_reposo ? bus.dat_escritura : r_dat_escritura;
  assign w_esc_mem       = w_en_reposo ? bus.esc_mem : r_esc_mem;
  assign w_tam           = w_en_reposo ? bus.tam : r_tam;
  assign w_sin_signo     = w_en_reposo ? bus.sin_signo : r_sin_signo;
  assign w_indice        = w_dir[ANCHO_IDX+1:2];
  assign w_palabra_ram   = r_ram[w_indice];

  assign w_entra_responde = reset &
                            ((w_en_reposo & bus.sol & SIN_ESPERA) |
                             ((r_estado == ESPERA) & (r_cuenta == '0)));
  assign w_escribe        = w_entra_responde & w_esc_mem & ~w_desalineado;

  alineador_bytes u_alineador (
    .i_tam           (w_tam),
    .i_dir_lo        (w_dir[1:0]),
    .i_sin_signo     (w_sin_signo),
    .i_dat_escritura (w_dat_escritura),
    .i_palabra_ram   (w_palabra_ram),
    .o_palabra_nueva (w_palabra_nueva),
    .o_dat_cargado   (w_dat_cargado),
    .o_desalineado   (w_desalineado)
  );

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_escribe) begin
      r_ram[w_indice] <= w_palabra_nueva;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado        <= REPOSO;
      r_cuenta        <= '0;
      r_dir           <= '0;
      r_dat_escritura <= '0;
      r_esc_mem       <= 1'b0;
      r_tam           <= BYTE;
      r_sin_signo     <= 1'b0;
      r_dat_lectura   <= '0;
      r_listo         <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_listo <= w_entra_responde;
      r_error <= w_entra_responde & w_desalineado;
      if (w_entra_responde) begin
        r_dat_lectura <= (w_esc_mem | w_desalineado) ? '0 : w_dat_cargado;
      end
      case (r_estado)
        REPOSO: begin
          if (bus.sol) begin
            r_dir           <= bus.dir[ANCHO_IDX+1:0];
            r_dat_escritura <= bus.dat_escritura;
            r_esc_mem       <= bus.esc_mem;
            r_tam           <= bus.tam;
            r_sin_signo     <= bus.sin_signo;
            if (SIN_ESPERA) begin
              r_estado <= RESPONDE;
            end else begin
              r_estado <= ESPERA;
              r_cuenta <= CARGA;
            end
          end
        end
        ESPERA: begin
          if (r_cuenta == '0) begin
            r_estado <= RESPONDE;
          end else begin
            r_cuenta <= r_cuenta - 1'b1;
          end
        end
        RESPONDE: r_estado <= REPOSO;
        default:  r_estado <= REPOSO;
      endcase
    end
  end

  assign bus.dat_lectura      = r_dat_lectura;
  assign bus.listo            = r_listo;
  assign bus.error_alineacion = r_error;

endmodule

// File: tb/tb_respondedor_memoria.sv
// Self-checking bench: LATENCIA=2 instance for data/lane/alignment/reset cases,
// LATENCIA=0 instance for continuous-request and address wrap behaviour.
module tb_respondedor_memoria;
  import respondedor_memoria_pkg::*;

  typedef struct {
    logic        esc;
    logic [31:0] dir;
    logic [31:0] dat;
    tam_t        tam;
    logic        ss;
    logic [31:0] exp_dat;
    logic        exp_err;
  } pet_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  pet_t esperados[$];

  respondedor_memoria_if bus ();
  respondedor_memoria_if bus0 ();

  respondedor_memoria #(.PALABRAS(256), .LATENCIA(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  respondedor_memoria #(.PALABRAS(256), .LATENCIA(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  function automatic pet_t pet(logic esc, logic [31:0] dir, logic [31:0] dat, tam_t tam,
                               logic ss, logic [31:0] exp_dat, logic exp_err);
    pet_t p;
    p.esc = esc; p.dir = dir; p.dat = dat; p.tam = tam; p.ss = ss;
    p.exp_dat = exp_dat; p.exp_err = exp_err;
    return p;
  endfunction

  task automatic aplicar(input pet_t p);
    bus.sol = 1'b1; bus.esc_mem = p.esc; bus.dir = p.dir;
    bus.dat_escritura = p.dat; bus.tam = p.tam; bus.sin_signo = p.ss;
  endtask

  task automatic aplicar0(input pet_t p);
    bus0.sol = 1'b1; bus0.esc_mem = p.esc; bus0.dir = p.dir;
    bus0.dat_escritura = p.dat; bus0.tam = p.tam; bus0.sin_signo = p.ss;
  endtask

  // Called at a negedge with the LATENCIA=2 instance idle; returns at a negedge, idle again.
  task automatic transaccion(input pet_t p, output logic [31:0] d, output logic e,
                             output int lat, output logic pulso_uno);
    aplicar(p);
    @(posedge clk);
    @(negedge clk);
    bus.sol = 1'b0;
    lat = 0;
    while (bus.listo !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (bus.listo !== 1'b1) lat = -1;
    d = bus.dat_lectura;
    e = bus.error_alineacion;
    @(negedge clk);
    pulso_uno = (bus.listo === 1'b0);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (bus.listo !== 1'b0) begin bad++; $display("FAIL reset listo got=%b want=0", bus.listo); end
    total++; if (bus.error_alineacion !== 1'b0) begin bad++; $display("FAIL reset error got=%b want=0", bus.error_alineacion); end
    total++; if (bus.dat_lectura !== 32'h0) begin bad++; $display("FAIL reset dat got=%h want=0", bus.dat_lectura); end
    total++; if (bus0.listo !== 1'b0) begin bad++; $display("FAIL reset0 listo got=%b want=0", bus0.listo); end
    total++; if (bus0.dat_lectura !== 32'h0) begin bad++; $display("FAIL reset0 dat got=%h want=0", bus0.dat_lectura); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_palabra;
    pet_t t[$];
    pet_t x;
    logic [31:0] d;
    logic e, uno;
    int lat;
    t.push_back(pet(1'b1, 32'h10,  32'hDEADBEEF, PALABRA, 1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b0, 32'h10,  32'h0,        PALABRA, 1'b0, 32'hDEADBEEF, 1'b0));
    t.push_back(pet(1'b0, 32'h410, 32'h0,        PALABRA, 1'b0, 32'hDEADBEEF, 1'b0));
    foreach (t[i]) begin
      esperados.push_back(t[i]);
      transaccion(t[i], d, e, lat, uno);
      x = esperados.pop_front();
      total++; if (d !== x.exp_dat) begin bad++; $display("FAIL palabra[%0d] dat got=%h want=%h", i, d, x.exp_dat); end
      total++; if (e !== x.exp_err) begin bad++; $display("FAIL palabra[%0d] error got=%b want=%b", i, e, x.exp_err); end
      total++; if (lat !== 2) begin bad++; $display("FAIL palabra[%0d] latency got=%0d want=2", i, lat); end
      total++; if (uno !== 1'b1) begin bad++; $display("FAIL palabra[%0d] listo width got=more want=1", i); end
    end
    repeat (3) @(negedge clk);
    total++; if (bus.dat_lectura !== 32'hDEADBEEF) begin bad++; $display("FAIL palabra hold dat got=%h want=deadbeef", bus.dat_lectura); end
    total++; if (bus.listo !== 1'b0) begin bad++; $display("FAIL palabra idle listo got=%b want=0", bus.listo); end
  endtask

  task automatic test_subpalabra;
    pet_t t[$];
    pet_t x;
    logic [31:0] d;
    logic e, uno;
    int lat;
    t.push_back(pet(1'b1, 32'h10, 32'h00000000, PALABRA, 1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b1, 32'h13, 32'h12345680, BYTE,    1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b0, 32'h13, 32'h0,        BYTE,    1'b0, 32'hFFFFFF80, 1'b0));
    t.push_back(pet(1'b0, 32'h13, 32'h0,        BYTE,    1'b1, 32'h00000080, 1'b0));
    t.push_back(pet(1'b0, 32'h10, 32'h0,        PALABRA, 1'b0, 32'h80000000, 1'b0));
    t.push_back(pet(1'b1, 32'h10, 32'h80011234, PALABRA, 1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b0, 32'h12, 32'h0,        MEDIA,   1'b0, 32'hFFFF8001, 1'b0));
    t.push_back(pet(1'b0, 32'h12, 32'h0,        MEDIA,   1'b1, 32'h00008001, 1'b0));
    t.push_back(pet(1'b0, 32'h11, 32'h0,        MEDIA,   1'b0, 32'h0,        1'b1));
    t.push_back(pet(1'b1, 32'h10, 32'hAAAA5678, MEDIA,   1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b0, 32'h10, 32'h0,        MEDIA,   1'b1, 32'h00005678, 1'b0));
    t.push_back(pet(1'b0, 32'h10, 32'h0,        PALABRA, 1'b0, 32'h80015678, 1'b0));
    foreach (t[i]) begin
      esperados.push_back(t[i]);
      transaccion(t[i], d, e, lat, uno);
      x = esperados.pop_front();
      total++; if (d !== x.exp_dat) begin bad++; $display("FAIL subpalabra[%0d] dat got=%h want=%h", i, d, x.exp_dat); end
      total++; if (e !== x.exp_err) begin bad++; $display("FAIL subpalabra[%0d] error got=%b want=%b", i, e, x.exp_err); end
      total++; if (lat !== 2) begin bad++; $display("FAIL subpalabra[%0d] latency got=%0d want=2", i, lat); end
      total++; if (uno !== 1'b1) begin bad++; $display("FAIL subpalabra[%0d] listo width got=more want=1", i); end
    end
  endtask

  task automatic test_desalineado;
    pet_t t[$];
    pet_t x;
    logic [31:0] d;
    logic e, uno;
    int lat;
    t.push_back(pet(1'b1, 32'h20, 32'h13572468, PALABRA,   1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b1, 32'h22, 32'hFFFFFFFF, PALABRA,   1'b0, 32'h0,        1'b1));
    t.push_back(pet(1'b0, 32'h20, 32'h0,        RESERVADO, 1'b0, 32'h0,        1'b1));
    t.push_back(pet(1'b0, 32'h20, 32'h0,        PALABRA,   1'b0, 32'h13572468, 1'b0));
    t.push_back(pet(1'b1, 32'h21, 32'hFFFFFFFF, MEDIA,     1'b0, 32'h0,        1'b1));
    t.push_back(pet(1'b0, 32'h20, 32'h0,        PALABRA,   1'b0, 32'h13572468, 1'b0));
    t.push_back(pet(1'b0, 32'h21, 32'h0,        BYTE,      1'b1, 32'h00000024, 1'b0));
    foreach (t[i]) begin
      esperados.push_back(t[i]);
      transaccion(t[i], d, e, lat, uno);
      x = esperados.pop_front();
      total++; if (d !== x.exp_dat) begin bad++; $display("FAIL desalineado[%0d] dat got=%h want=%h", i, d, x.exp_dat); end
      total++; if (e !== x.exp_err) begin bad++; $display("FAIL desalineado[%0d] error got=%b want=%b", i, e, x.exp_err); end
      total++; if (lat !== 2) begin bad++; $display("FAIL desalineado[%0d] latency got=%0d want=2", i, lat); end
    end
  endtask

  task automatic test_reset_en_espera;
    logic [31:0] d;
    logic e, uno;
    int lat;
    int vistos;
    transaccion(pet(1'b1, 32'h30, 32'h11111111, PALABRA, 1'b0, 32'h0, 1'b0), d, e, lat, uno);
    total++; if (lat !== 2) begin bad++; $display("FAIL resetespera setup latency got=%0d want=2", lat); end
    aplicar(pet(1'b1, 32'h30, 32'h22222222, PALABRA, 1'b0, 32'h0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.sol = 1'b0;
    reset   = 1'b0;
    vistos  = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.listo !== 1'b0) vistos++;
    end
    total++; if (vistos != 0) begin bad++; $display("FAIL resetespera listo pulses got=%0d want=0", vistos); end
    total++; if (bus.dat_lectura !== 32'h0) begin bad++; $display("FAIL resetespera dat got=%h want=0", bus.dat_lectura); end
    reset = 1'b1;
    esperados.push_back(pet(1'b0, 32'h30, 32'h0, PALABRA, 1'b0, 32'h11111111, 1'b0));
    transaccion(esperados[0], d, e, lat, uno);
    begin
      pet_t x;
      x = esperados.pop_front();
      total++; if (d !== x.exp_dat) begin bad++; $display("FAIL resetespera load dat got=%h want=%h", d, x.exp_dat); end
      total++; if (lat !== 2) begin bad++; $display("FAIL resetespera accept latency got=%0d want=2", lat); end
    end
  endtask

  task automatic test_latencia_cero;
    pet_t t[$];
    pet_t x;
    logic exp_listo;
    t.push_back(pet(1'b1, 32'h400, 32'hCAFEF00D, PALABRA, 1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b1, 32'h000, 32'hBADBADBA, PALABRA, 1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b0, 32'h000, 32'h0,        PALABRA, 1'b0, 32'hCAFEF00D, 1'b0));
    t.push_back(pet(1'b1, 32'h000, 32'hBADBADBA, PALABRA, 1'b0, 32'h0,        1'b0));
    t.push_back(pet(1'b0, 32'h401, 32'h0,        BYTE,    1'b1, 32'h000000F0, 1'b0));
    t.push_back(pet(1'b1, 32'h000, 32'hBADBADBA, PALABRA, 1'b0, 32'h0,        1'b0));
    aplicar0(t[0]);
    esperados.push_back(t[0]);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_listo = (k % 2 == 1);
      total++; if (bus0.listo !== exp_listo) begin bad++; $display("FAIL lat0 listo cycle %0d got=%b want=%b", k, bus0.listo, exp_listo); end
      if (bus0.listo === 1'b1 && esperados.size() > 0) begin
        x = esperados.pop_front();
        total++; if (bus0.dat_lectura !== x.exp_dat) begin bad++; $display("FAIL lat0 dat cycle %0d got=%h want=%h", k, bus0.dat_lectura, x.exp_dat); end
        total++; if (bus0.error_alineacion !== x.exp_err) begin bad++; $display("FAIL lat0 error cycle %0d got=%b want=%b", k, bus0.error_alineacion, x.exp_err); end
      end
      if (k < 6) begin
        aplicar0(t[k]);
        if (k % 2 == 0) esperados.push_back(t[k]);
      end else begin
        bus0.sol = 1'b0;
      end
    end
    total++; if (esperados.size() != 0) begin bad++; $display("FAIL lat0 pending responses got=%0d want=0", esperados.size()); end
  endtask

  initial begin
    bus.sol = 1'b0;  bus.esc_mem = 1'b0;  bus.dir = '0;  bus.dat_escritura = '0;  bus.tam = BYTE;  bus.sin_signo = 1'b0;
    bus0.sol = 1'b0; bus0.esc_mem = 1'b0; bus0.dir = '0; bus0.dat_escritura = '0; bus0.tam = BYTE; bus0.sin_signo = 1'b0;
    test_reset();
    test_palabra();
    test_subpalabra();
    test_desalineado();
    test_reset_en_espera();
    test_latencia_cero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
